dec_pipe_param: RTL and testbench
=================================

Name: dec_pipe_param

Overview:
- Parametrised, registered successor to the team's combinational N-to-2^N decoder.
- Decodes a binary code into an OUT_W-bit vector in one of four output modes. Flags codes that are out of range for OUT_W.
- Uses a single-stage valid/ready pipeline register so it can sit between streaming blocks.
- Keeps a saturating count of range errors.

Parameters:
- IN_W, 4, width of the input code.
- OUT_W, 16, width of the decoded output; legal range 2 to 2**IN_W.
- CNT_W, 8, width of the saturating range-error counter.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  decode enable; a transfer with en=0 produces an all-inactive output.
- mode  in  2  output mode, sampled with the transfer: 0 one-hot, 1 thermometer, 2 active-low one-hot, 3 upper mask.
- in_valid  in  1  input code valid.
- in_ready  out  1  block can accept a code.
- in_code  in  IN_W  binary code.
- out_valid  out  1  out_data/out_err hold a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  decoded vector.
- out_err  out  1  the result came from an out-of-range code (in_code >= OUT_W) with en=1.
- err_cnt  out  CNT_W  saturating count of accepted out-of-range codes.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, out_data=0, out_err=0, err_cnt=0. in_ready rises with reset deasserted, since out_valid=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble under continuous flow).
  - Input transfer occurs on a clk edge with in_valid && in_ready.
  - Output transfer occurs on a clk edge with out_valid && out_ready.
- Latency: 1 cycle. A code accepted at edge k is visible on out_data at edge k with out_valid=1. It holds stable until the output transfer.
- out_valid update each edge:
  - set on an input transfer;
  - otherwise cleared on an output transfer;
  - otherwise held.
  - A simultaneous input and output transfer reloads the register with the new result; out_valid stays 1.
- Decode function, with c = in_code and i = bit index 0..OUT_W-1:
  - mode 0: bit i = (i == c).
  - mode 1: bit i = (i <= c). Example: c=3 gives 0x000F.
  - mode 2: bit i = (i != c). Example: c=0 gives 0xFFFE.
  - mode 3: bit i = (i >= c). Example: c=3 gives 0xFFF8.
- en=0: output is all-inactive (0 for modes 0, 1, 3; all-ones for mode 2). out_err=0 and err_cnt is unchanged.
- Out of range (en=1, c >= OUT_W):
  - output is all-inactive as for en=0;
  - out_err=1;
  - err_cnt increments by 1 on the accepting edge, saturating at 2**CNT_W-1.
  - Out-of-range codes are only possible when OUT_W < 2**IN_W.
- err_clr: clears err_cnt to 0 on the edge.
  - If err_clr and an erroring transfer occur on the same edge, err_cnt becomes 1 (clear takes effect first, then the increment).
- Back-pressure: while out_valid=1 and out_ready=0, in_ready=0. Input is ignored, and out_data/out_err/err_cnt do not change except through err_clr.
- Reset mid-transfer: the pending result is discarded with no output transfer, and err_cnt returns to 0.
- No state machine beyond the valid flag. All arithmetic is unsigned, and comparisons are done at IN_W width.

Decomposition:
- Shared package dec_pkg holds:
  - the mode encodings as named constants (DEC_ONEHOT=0, DEC_THERM=1, DEC_ONEHOT_N=2, DEC_UMASK=3);
  - the inactive-value rule per mode.
- One combinational sub-module, dec_core, computes out vector and err from en, mode and code. dec_pipe_param wraps it with the pipeline register, handshake logic and error counter.

Test Plan:
- Defaults, out_ready=1, en=1, mode 0, codes 0..15 back-to-back: outputs are 0x0001..0x8000, one per cycle, in_ready held at 1.
- Sweep modes 1, 2, 3 with code 3: outputs are 0x000F, 0xFFF7 and 0xFFF8 respectively. For mode 2, en=0 gives 0xFFFF with out_err=0.
- OUT_W=10, IN_W=4, code 12 in mode 0: out_data=0x000, out_err=1, err_cnt=1. Repeat with CNT_W=2 and 5 errors: err_cnt saturates at 3. err_clr plus an error on the same edge gives err_cnt=1.
- Hold out_ready=0 after one accepted code 5: out_valid=1, in_ready=0, out_data stable at 0x0020 while in_code changes. Raising out_ready with in_valid=1 and code 6 gives a simultaneous transfer; the next cycle shows 0x0040 and no bubble.
- Assert rst asynchronously mid-cycle with out_valid=1 and err_cnt=2: out_valid, out_data and err_cnt go to 0 immediately, before the next edge. After release, in_ready=1 and the first code decodes normally.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the registered decoder: mode encodings and the
// per-mode inactive output level.
package dec_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT   = 2'd0,
    DEC_THERM    = 2'd1,
    DEC_ONEHOT_N = 2'd2,
    DEC_UMASK    = 2'd3
  } dec_mode_e;

  // Level every output bit takes when the decode is suppressed (en=0 or bad code).
  function automatic logic inactive_bit(input dec_mode_e mode);
    return (mode == DEC_ONEHOT_N);
  endfunction

endpackage

// File: rtl/dec_core.sv
// Combinational decode of a binary code into one of four OUT_W-bit patterns,
// with an out-of-range flag for codes that have no output bit.
module dec_core
  import dec_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  // When OUT_W covers every code value no code can be out of range.
  localparam bit              FULL  = (OUT_W >= (1 << IN_W));
  localparam logic [IN_W-1:0] LIMIT = FULL ? '0 : IN_W'(OUT_W);

  dec_mode_e mode_e;
  logic      in_range;

  assign mode_e   = dec_mode_e'(mode);
  assign in_range = FULL || (code < LIMIT);

  always_comb begin
    // NOTE: data and err get a default before any branch so no latch is inferred.
    data = {OUT_W{inactive_bit(mode_e)}};
    err  = en && !in_range;
    if (en && in_range) begin
      for (int i = 0; i < OUT_W; i++) begin
        unique case (mode_e)
          DEC_ONEHOT:   data[i] = (IN_W'(i) == code);
          DEC_THERM:    data[i] = (IN_W'(i) <= code);
          DEC_ONEHOT_N: data[i] = (IN_W'(i) != code);
          DEC_UMASK:    data[i] = (IN_W'(i) >= code);
          default:      data[i] = 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/dec_pipe_param.sv
// Registered decoder: dec_core behind a single valid/ready stage, plus a
// saturating counter of accepted out-of-range codes.
module dec_pipe_param
  import dec_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OUT_W-1:0] core_data;
  logic             core_err;
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] cnt_next;

  dec_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .en   (en),
    .mode (mode),
    .code (in_code),
    .data (core_data),
    .err  (core_err)
  );

  // A full stage still accepts when the downstream drains it on the same edge.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Clear applies before the increment, so clear plus an error yields 1.
  always_comb begin
    cnt_next = err_clr ? '0 : err_cnt;
    if (in_fire && core_err && (cnt_next != CNT_MAX)) begin
      cnt_next = cnt_next + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= core_data;
        out_err   <= core_err;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      err_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_dec_pipe_param.sv
// Self-checking bench: a default-sized instance for decode/handshake and a
// narrow instance (OUT_W=10, CNT_W=2) for range errors and counter saturation.
module tb_dec_pipe_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults (IN_W=4, OUT_W=16, CNT_W=8)
  logic        en_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_err_a, err_clr_a;
  logic [1:0]  mode_a;
  logic [3:0]  in_code_a;
  logic [15:0] out_data_a;
  logic [7:0]  err_cnt_a;

  // Instance B: IN_W=4, OUT_W=10, CNT_W=2
  logic        en_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b, err_clr_b;
  logic [1:0]  mode_b;
  logic [3:0]  in_code_b;
  logic [9:0]  out_data_b;
  logic [1:0]  err_cnt_b;

  dec_pipe_param dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_code(in_code_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_err(out_err_a), .err_cnt(err_cnt_a), .err_clr(err_clr_a)
  );

  dec_pipe_param #(.IN_W(4), .OUT_W(10), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_code(in_code_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_err(out_err_b), .err_cnt(err_cnt_b), .err_clr(err_clr_b)
  );

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  code;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_a_t;

  typedef struct {
    logic        valid;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  code;
    logic        clr;
    logic [9:0]  exp_data;
    logic        exp_err;
    logic [1:0]  exp_cnt;
  } vec_b_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t   sb[$];
  vec_a_t tab_a[$];
  vec_b_t tab_b[$];
  int     n_total = 0;
  int     n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive instance A for one cycle; an accepted code pushes its expectation and
  // the result register is compared against the popped entry after the edge.
  task automatic step_a(input logic v, input logic e, input logic [1:0] m, input logic [3:0] c,
                        input logic rdy, input logic [15:0] xd, input logic xe, output logic fire);
    exp_t x;
    @(negedge clk);
    in_valid_a = v; en_a = e; mode_a = m; in_code_a = c; out_ready_a = rdy;
    #4;
    fire = in_valid_a && in_ready_a;
    if (fire) sb.push_back('{data: xd, err: xe});
    @(posedge clk);
    #1;
    if (fire) begin
      if (sb.size() == 0) begin
        check("a_sb_empty", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        check($sformatf("a_data m%0d c%0d", m, c), 32'(out_data_a), 32'(x.data));
        check($sformatf("a_err m%0d c%0d", m, c), 32'(out_err_a), 32'(x.err));
        check("a_valid", 32'(out_valid_a), 32'd1);
      end
    end
  endtask

  task automatic step_b(input logic v, input logic e, input logic [1:0] m, input logic [3:0] c,
                        input logic clr, input logic rdy);
    @(negedge clk);
    in_valid_b = v; en_b = e; mode_b = m; in_code_b = c; err_clr_b = clr; out_ready_b = rdy;
    @(posedge clk);
    #1;
    err_clr_b = 1'b0;
  endtask

  initial begin
    logic fire;

    rst = 1'b1;
    {en_a, in_valid_a, out_ready_a, err_clr_a, mode_a, in_code_a} = '0;
    {en_b, in_valid_b, out_ready_b, err_clr_b, mode_b, in_code_b} = '0;
    out_ready_a = 1'b1;

    for (int c = 0; c < 16; c++) tab_a.push_back('{1'b1, 2'd0, 4'(c), 16'd1 << c, 1'b0});
    tab_a.push_back('{1'b1, 2'd1, 4'd3,  16'h000F, 1'b0});
    tab_a.push_back('{1'b1, 2'd2, 4'd3,  16'hFFF7, 1'b0});
    tab_a.push_back('{1'b1, 2'd3, 4'd3,  16'hFFF8, 1'b0});
    tab_a.push_back('{1'b0, 2'd2, 4'd3,  16'hFFFF, 1'b0});
    tab_a.push_back('{1'b0, 2'd0, 4'd7,  16'h0000, 1'b0});
    tab_a.push_back('{1'b1, 2'd1, 4'd15, 16'hFFFF, 1'b0});
    tab_a.push_back('{1'b1, 2'd1, 4'd0,  16'h0001, 1'b0});
    tab_a.push_back('{1'b1, 2'd2, 4'd0,  16'hFFFE, 1'b0});
    tab_a.push_back('{1'b1, 2'd3, 4'd0,  16'hFFFF, 1'b0});
    tab_a.push_back('{1'b1, 2'd3, 4'd15, 16'h8000, 1'b0});

    //               valid en    mode  code   clr   data     err   cnt
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd12, 1'b0, 10'h000, 1'b1, 2'd1});
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd12, 1'b0, 10'h000, 1'b1, 2'd2});
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd12, 1'b0, 10'h000, 1'b1, 2'd3});
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd12, 1'b0, 10'h000, 1'b1, 2'd3});
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd12, 1'b0, 10'h000, 1'b1, 2'd3});
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd9,  1'b0, 10'h200, 1'b0, 2'd3});
    tab_b.push_back('{1'b1, 1'b1, 2'd2, 4'd10, 1'b0, 10'h3FF, 1'b1, 2'd3});
    tab_b.push_back('{1'b1, 1'b0, 2'd0, 4'd12, 1'b0, 10'h000, 1'b0, 2'd3});
    tab_b.push_back('{1'b1, 1'b0, 2'd2, 4'd12, 1'b0, 10'h3FF, 1'b0, 2'd3});
    tab_b.push_back('{1'b0, 1'b1, 2'd0, 4'd0,  1'b1, 10'h3FF, 1'b0, 2'd0});
    tab_b.push_back('{1'b1, 1'b1, 2'd3, 4'd15, 1'b0, 10'h000, 1'b1, 2'd1});
    tab_b.push_back('{1'b1, 1'b1, 2'd1, 4'd11, 1'b0, 10'h000, 1'b1, 2'd2});
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd12, 1'b1, 10'h000, 1'b1, 2'd1});
    tab_b.push_back('{1'b1, 1'b1, 2'd0, 4'd13, 1'b0, 10'h000, 1'b1, 2'd2});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid_a), 32'd0);
    check("rst_data",  32'(out_data_a),  32'd0);
    check("rst_err",   32'(out_err_a),   32'd0);
    check("rst_cnt_b", 32'(err_cnt_b),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready_a), 32'd1);

    // Back-to-back decode with out_ready=1; in_ready must never drop
    foreach (tab_a[k]) begin
      step_a(1'b1, tab_a[k].en, tab_a[k].mode, tab_a[k].code, 1'b1,
             tab_a[k].exp_data, tab_a[k].exp_err, fire);
      check($sformatf("a_accept %0d", k), 32'(fire), 32'd1);
    end

    // Back-pressure: code 5 accepted, then held while in_code wanders
    step_a(1'b1, 1'b1, 2'd0, 4'd5, 1'b1, 16'h0020, 1'b0, fire);
    for (int k = 0; k < 2; k++) begin
      step_a(1'b1, 1'b1, 2'd0, 4'(9 + k), 1'b0, 16'h0000, 1'b0, fire);
      check("bp_no_accept", 32'(fire), 32'd0);
      check("bp_in_ready",  32'(in_ready_a), 32'd0);
      check("bp_valid",     32'(out_valid_a), 32'd1);
      check("bp_data",      32'(out_data_a), 32'h0020);
    end
    step_a(1'b1, 1'b1, 2'd0, 4'd6, 1'b1, 16'h0040, 1'b0, fire);
    check("bp_simul_accept", 32'(fire), 32'd1);
    step_a(1'b1, 1'b1, 2'd0, 4'd7, 1'b1, 16'h0080, 1'b0, fire);
    check("bp_no_bubble", 32'(fire), 32'd1);
    // Leave A holding a result for the reset test
    step_a(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 16'h0000, 1'b0, fire);
    check("a_hold_valid", 32'(out_valid_a), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Range errors, saturation and clear on instance B
    foreach (tab_b[k]) begin
      step_b(tab_b[k].valid, tab_b[k].en, tab_b[k].mode, tab_b[k].code, tab_b[k].clr, 1'b1);
      if (tab_b[k].valid) begin
        check($sformatf("b_data %0d", k), 32'(out_data_b), 32'(tab_b[k].exp_data));
        check($sformatf("b_err %0d", k),  32'(out_err_b),  32'(tab_b[k].exp_err));
      end
      check($sformatf("b_cnt %0d", k), 32'(err_cnt_b), 32'(tab_b[k].exp_cnt));
    end
    step_b(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);
    check("b_pre_rst_valid", 32'(out_valid_b), 32'd1);
    check("b_pre_rst_cnt",   32'(err_cnt_b),   32'd2);

    // Asynchronous reset mid-cycle: state clears before the next edge
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_a", 32'(out_valid_a), 32'd0);
    check("arst_data_a",  32'(out_data_a),  32'd0);
    check("arst_valid_b", 32'(out_valid_b), 32'd0);
    check("arst_cnt_b",   32'(err_cnt_b),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready_a), 32'd1);
    step_a(1'b1, 1'b1, 2'd0, 4'd2, 1'b1, 16'h0004, 1'b0, fire);
    check("post_rst_accept", 32'(fire), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
